// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// One quotient bit per clock. The result {remainder, quotient} is held while start_i
// stays high after ready_o; dropping start_i returns the unit to FREE and clears it.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, overrides everything
//   signed_div_i  1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i     dividend, sampled only on the accepting edge
//   opdata2_i     divisor, sampled only on the accepting edge
//   start_i       request, held high until the result has been consumed
//   annul_i       cancels a new request in FREE or an in-flight one in ON
//   result_o      {remainder, quotient}, meaningful while ready_o = 1
//   ready_o       result valid
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   dvd_q;     // dividend bits not yet consumed, quotient bits shifted in below
    logic [DATA_W-1:0]   dvs_q;     // divisor magnitude
    logic [DATA_W-1:0]   rem_q;     // partial remainder, always < divisor so DATA_W bits suffice
    logic [CNT_W-1:0]    cnt_q;
    logic                signed_q;
    logic                sign1_q;
    logic                sign2_q;

    logic [DATA_W:0]     shifted;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   quot_next;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   abs1;
    logic [DATA_W-1:0]   abs2;

    // One restoring step plus the final sign correction and operand magnitudes.
    always_comb begin
        shifted   = {rem_q, dvd_q[DATA_W-1]};
        // trial = shifted - divisor is non-negative exactly when shifted >= divisor
        q_bit     = (shifted >= {1'b0, dvs_q});
        rem_next  = q_bit ? DATA_W'(shifted - {1'b0, dvs_q}) : shifted[DATA_W-1:0];
        quot_next = {dvd_q[DATA_W-2:0], q_bit};
        // Truncation toward zero: quotient sign is the XOR, remainder follows the dividend.
        quot_fix  = (signed_q && (sign1_q ^ sign2_q)) ? DATA_W'(~quot_next + DATA_W'(1)) : quot_next;
        rem_fix   = (signed_q && sign1_q) ? DATA_W'(~rem_next + DATA_W'(1)) : rem_next;
        abs1      = (signed_div_i && opdata1_i[DATA_W-1]) ? DATA_W'(~opdata1_i + DATA_W'(1)) : opdata1_i;
        abs2      = (signed_div_i && opdata2_i[DATA_W-1]) ? DATA_W'(~opdata2_i + DATA_W'(1)) : opdata2_i;
    end

    // Control FSM with registered result/ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= S_DIVZERO;
                        end else begin
                            dvd_q    <= abs1;
                            dvs_q    <= abs2;
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            signed_q <= signed_div_i;
                            sign1_q  <= opdata1_i[DATA_W-1];
                            sign2_q  <= opdata2_i[DATA_W-1];
                            state    <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= S_END;
                end
                S_ON: begin
                    if (annul_i) begin
                        cnt_q <= '0;
                        state <= S_FREE;
                    end else begin
                        dvd_q <= quot_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                            state    <= S_END;
                        end
                    end
                end
                S_END: begin
                    // Hold the result until EX releases start_i.
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= S_FREE;
                    end
                end
                default: begin
                    state <= S_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-level expectation (exp_ready/exp_result)
// driven from the stimulus, compared every cycle, plus literal result checks.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int          checks = 0;
    int          errors = 0;
    logic        exp_ready;
    logic [63:0] exp_result;
    bit          chk_en = 1'b0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic division with truncation toward zero.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Per-cycle comparison against the expected output state.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (ready_o !== exp_ready || result_o !== exp_result) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t ready=%b result=%h expected ready=%b result=%h",
                         $time, ready_o, result_o, exp_ready, exp_result);
            end
        end
    end

    task automatic check_lit(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request; annul_at/rst_at (1-based iteration edge, 0 = none) abort it.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input int annul_at, input int rst_at,
                           output logic [63:0] got);
        int lat;
        bit aborted;
        got          = 64'd0;
        aborted      = 1'b0;
        lat          = (b == 32'd0) ? 1 : 32;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
        tick();
        // Operand changes after acceptance must be ignored.
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = 1'($urandom_range(0, 1));
        for (int k = 1; k <= lat; k++) begin
            if (k == annul_at && b != 32'd0) annul_i = 1'b1;
            if (k == rst_at) rst = 1'b1;
            tick();
            if (annul_i || rst) begin
                annul_i = 1'b0;
                rst     = 1'b0;
                start_i = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (k == lat) begin
                exp_ready  = 1'b1;
                exp_result = ref_div(s, a, b);
            end
        end
        if (!aborted) begin
            got = result_o;
            for (int h = 0; h < hold; h++) begin
                annul_i = 1'($urandom_range(0, 1));
                tick();
            end
            annul_i = 1'b0;
            start_i = 1'b0;
            tick();
            exp_ready  = 1'b0;
            exp_result = 64'd0;
        end else begin
            tick();
        end
    endtask

    initial begin
        logic [63:0] got;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          ann;
        int          rsa;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        exp_ready    = 1'b0;
        exp_result   = 64'd0;
        repeat (2) tick();
        chk_en = 1'b1;
        check_lit("reset_result", result_o, 64'd0);
        check_lit("reset_ready", {63'd0, ready_o}, 64'd0);
        rst = 1'b0;
        tick();

        // Pin the reference model with hand-computed values.
        check_lit("model_divu_100_7", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        check_lit("model_div_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        check_lit("model_div_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), 64'h00000000_80000000);

        run_div(1'b0, 32'd100, 32'd7, 0, 0, 0, got);
        check_lit("divu_100_7", got, 64'h00000002_0000000E);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, got);
        check_lit("div_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, got);
        check_lit("div_7_m2", got, 64'h00000001_FFFFFFFD);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, got);
        check_lit("div_ovf", got, 64'h00000000_80000000);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, got);
        check_lit("divu_big", got, 64'h80000000_00000000);
        run_div(1'b1, 32'd1234, 32'd0, 1, 0, 0, got);
        check_lit("div_by_zero", got, 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, got);
        check_lit("divu_by_zero", got, 64'd0);

        // Cancel mid-operation, then a normal request.
        run_div(1'b0, 32'd5000, 32'd17, 0, 10, 0, got);
        run_div(1'b0, 32'd9, 32'd3, 0, 0, 0, got);
        check_lit("divu_9_3_after_annul", got, 64'h00000000_00000003);

        // start with annul in FREE is ignored.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        run_div(1'b0, 32'd1000, 32'd33, 5, 0, 0, got);
        check_lit("divu_hold5", got, 64'h0000000A_0000001E);

        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 0, 20, got);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, got);
        check_lit("div_m100_7_after_rst", got, 64'hFFFFFFFE_FFFFFFF2);

        // Randomized requests checked cycle by cycle against the model.
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'(-$signed(32'($urandom_range(1, 15))));
                default: b = 32'($urandom);
            endcase
            ann = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 32) : 0;
            rsa = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 32) : 0;
            run_div(s, a, b, $urandom_range(0, 3), ann, rsa, got);
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
